sram_arbiter: RTL and testbench

- Two-requester arbiter in front of the single-port SRAM controller.
- Port 0 carries instruction fetch traffic and port 1 carries memory-stage data traffic.
- Grants one transaction at a time under round-robin priority. It latches the winning command and drives the controller's rd/wr enables until the controller signals completion.
- It returns per-port ready (freeze) and 64-bit read data to the pipeline.

---
 rtl/sram_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin front end for the single-port SRAM controller.
// Port 0 carries instruction fetches and port 1 carries data accesses. One command is
// latched at a time and replayed to the controller until it reports completion.
module sram_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int WDATA_W = 32,
  parameter int RDATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_rd_en,
  input  logic               p0_wr_en,
  input  logic [ADDR_W-1:0]  p0_addr,
  input  logic [WDATA_W-1:0] p0_write_data,
  output logic [RDATA_W-1:0] p0_read_data,
  output logic               p0_ready,
  input  logic               p1_rd_en,
  input  logic               p1_wr_en,
  input  logic [ADDR_W-1:0]  p1_addr,
  input  logic [WDATA_W-1:0] p1_write_data,
  output logic [RDATA_W-1:0] p1_read_data,
  output logic               p1_ready,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_write_data,
  input  logic [RDATA_W-1:0] mem_read_data,
  input  logic               mem_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  state_t state_nxt;

  logic               req0;
  logic               req1;
  logic               win;
  logic               grant_fire;
  logic               complete;
  logic               is_read;
  logic               gnt;
  logic               last;
  logic               cmd_wr;
  logic               cmd_rd;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [WDATA_W-1:0] cmd_wdata;
  logic [RDATA_W-1:0] rdata_hold0;
  logic [RDATA_W-1:0] rdata_hold1;

  assign req0       = p0_rd_en | p0_wr_en;
  assign req1       = p1_rd_en | p1_wr_en;
  assign grant_fire = (state == IDLE) & (req0 | req1);
  assign complete   = (state == BUSY) & mem_ready;
  // A request with both enables set is a write, so it never counts as a read.
  assign is_read    = cmd_rd & ~cmd_wr;

  // Pick the winner: the lone requester, or on a tie the port not served last.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave IDLE on any request, leave BUSY when the controller completes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = BUSY;
      BUSY:    if (mem_ready)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning command on grant; record the served port and capture read data on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt         <= 1'b0;
      last        <= 1'b1;
      cmd_wr      <= 1'b0;
      cmd_rd      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      rdata_hold0 <= '0;
      rdata_hold1 <= '0;
    end else begin
      if (grant_fire) begin
        gnt <= win;
        if (win) begin
          cmd_wr    <= p1_wr_en;
          cmd_rd    <= p1_rd_en;
          cmd_addr  <= p1_addr;
          cmd_wdata <= p1_write_data;
        end else begin
          cmd_wr    <= p0_wr_en;
          cmd_rd    <= p0_rd_en;
          cmd_addr  <= p0_addr;
          cmd_wdata <= p0_write_data;
        end
      end
      if (complete) begin
        last   <= gnt;
        cmd_rd <= 1'b0;
        cmd_wr <= 1'b0;
        if (is_read) begin
          if (gnt) begin
            rdata_hold1 <= mem_read_data;
          end else begin
            rdata_hold0 <= mem_read_data;
          end
        end
      end
    end
  end

  // Controller strobes come straight from the latched command; ready and read data bypass on completion.
  // While reset is held the pipeline is never frozen, so both readies are forced high.
  always_comb begin
    mem_rd_en      = (state == BUSY) & is_read;
    mem_wr_en      = (state == BUSY) & cmd_wr;
    mem_addr       = cmd_addr;
    mem_write_data = cmd_wdata;
    p0_ready       = ~rst | ~req0 | (complete & ~gnt);
    p1_ready       = ~rst | ~req1 | (complete & gnt);
    p0_read_data   = (complete & ~gnt & is_read) ? mem_read_data : rdata_hold0;
    p1_read_data   = (complete & gnt & is_read)  ? mem_read_data : rdata_hold1;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector table plus hand-written multi-cycle sequences for sram_arbiter.
// A small controller model completes every access in its sixth enabled cycle.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_rd_en;
  logic        p0_wr_en;
  logic [17:0] p0_addr;
  logic [31:0] p0_write_data;
  logic [63:0] p0_read_data;
  logic        p0_ready;
  logic        p1_rd_en;
  logic        p1_wr_en;
  logic [17:0] p1_addr;
  logic [31:0] p1_write_data;
  logic [63:0] p1_read_data;
  logic        p1_ready;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [17:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [63:0] mem_read_data;
  logic        mem_ready;
  logic [2:0]  busy_cnt;

  int compared;
  int mismatched;

  typedef struct {
    logic        rst;
    logic        p0_rd;
    logic        p0_wr;
    logic [17:0] p0_a;
    logic [31:0] p0_wd;
    logic        p1_rd;
    logic        p1_wr;
    logic [17:0] p1_a;
    logic [31:0] p1_wd;
    logic [63:0] mrd;
    logic        e_rd;
    logic        e_wr;
    logic [17:0] e_addr;
    logic [31:0] e_wd;
    logic        e_r0;
    logic        e_r1;
    logic [63:0] e_d0;
    logic [63:0] e_d1;
  } vec_t;

  vec_t vecs[19];

  sram_arbiter #(.ADDR_W(18), .WDATA_W(32), .RDATA_W(64)) dut (
    .clk(clk),
    .rst(rst),
    .p0_rd_en(p0_rd_en),
    .p0_wr_en(p0_wr_en),
    .p0_addr(p0_addr),
    .p0_write_data(p0_write_data),
    .p0_read_data(p0_read_data),
    .p0_ready(p0_ready),
    .p1_rd_en(p1_rd_en),
    .p1_wr_en(p1_wr_en),
    .p1_addr(p1_addr),
    .p1_write_data(p1_write_data),
    .p1_read_data(p1_read_data),
    .p1_ready(p1_ready),
    .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: counts enabled cycles and raises ready in the sixth, idle-high otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt <= 3'd0;
    end else if (mem_rd_en || mem_wr_en) begin
      busy_cnt <= busy_cnt + 3'd1;
    end else begin
      busy_cnt <= 3'd0;
    end
  end
  assign mem_ready = ~(mem_rd_en | mem_wr_en) | (busy_cnt == 3'd5);

  function automatic vec_t mk(
    input logic rs, input logic a_rd, input logic a_wr, input logic [17:0] a_a, input logic [31:0] a_wd,
    input logic b_rd, input logic b_wr, input logic [17:0] b_a, input logic [31:0] b_wd, input logic [63:0] mrd,
    input logic e_rd, input logic e_wr, input logic [17:0] e_addr, input logic [31:0] e_wd,
    input logic e_r0, input logic e_r1, input logic [63:0] e_d0, input logic [63:0] e_d1);
    vec_t v;
    v.rst = rs;     v.p0_rd = a_rd; v.p0_wr = a_wr; v.p0_a = a_a; v.p0_wd = a_wd;
    v.p1_rd = b_rd; v.p1_wr = b_wr; v.p1_a = b_a;   v.p1_wd = b_wd; v.mrd = mrd;
    v.e_rd = e_rd;  v.e_wr = e_wr;  v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_r0 = e_r0;  v.e_r1 = e_r1;  v.e_d0 = e_d0;  v.e_d1 = e_d1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    p0_rd_en      = v.p0_rd;
    p0_wr_en      = v.p0_wr;
    p0_addr       = v.p0_a;
    p0_write_data = v.p0_wd;
    p1_rd_en      = v.p1_rd;
    p1_wr_en      = v.p1_wr;
    p1_addr       = v.p1_a;
    p1_write_data = v.p1_wd;
    mem_read_data = v.mrd;
    #1;
  endtask

  task automatic idleInputs();
    p0_rd_en = 1'b0; p0_wr_en = 1'b0; p0_addr = '0; p0_write_data = '0;
    p1_rd_en = 1'b0; p1_wr_en = 1'b0; p1_addr = '0; p1_write_data = '0;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    idleInputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Watchdog so the run always ends even if the sequences stall.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    logic [17:0] ra;
    logic [17:0] wa;
    logic [31:0] wd;
    logic [63:0] rdv;
    logic [63:0] junk;
    logic [63:0] wjunk;
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b0;
    mem_read_data = '0;
    idleInputs();

    ra    = 18'h00100;
    wa    = 18'h3FFFF;
    wd    = 32'hDEADBEEF;
    rdv   = 64'h0123_4567_89AB_CDEF;
    junk  = 64'hFFFF_0000_FFFF_0000;
    wjunk = 64'hAAAA_5555_AAAA_5555;

    // Reset with live requests, release, single read on port 0, single write on port 1.
    vecs[0]  = mk(0, 1, 0, 18'h155, 32'h0,  0, 1, 18'h2AA, 32'h12345678, junk,  0, 0, 18'h0, 32'h0, 1, 1, 64'h0, 64'h0);
    vecs[1]  = mk(0, 0, 1, 18'h0AA, 32'h55, 1, 0, 18'h011, 32'h0,        junk,  0, 0, 18'h0, 32'h0, 1, 1, 64'h0, 64'h0);
    vecs[2]  = mk(1, 0, 0, 18'h0,   32'h0,  0, 0, 18'h0,   32'h0,        junk,  0, 0, 18'h0, 32'h0, 1, 1, 64'h0, 64'h0);
    vecs[3]  = mk(1, 1, 0, ra,      32'h0,  0, 0, 18'h0,   32'h0,        rdv,   0, 0, 18'h0, 32'h0, 0, 1, 64'h0, 64'h0);
    for (int i = 4; i <= 8; i++)
      vecs[i] = mk(1, 1, 0, ra,     32'h0,  0, 0, 18'h0,   32'h0,        rdv,   1, 0, ra,    32'h0, 0, 1, 64'h0, 64'h0);
    vecs[9]  = mk(1, 1, 0, ra,      32'h0,  0, 0, 18'h0,   32'h0,        rdv,   1, 0, ra,    32'h0, 1, 1, rdv,   64'h0);
    vecs[10] = mk(1, 0, 0, 18'h0,   32'h0,  0, 0, 18'h0,   32'h0,        junk,  0, 0, ra,    32'h0, 1, 1, rdv,   64'h0);
    vecs[11] = mk(1, 0, 0, 18'h0,   32'h0,  0, 1, wa,      wd,           wjunk, 0, 0, ra,    32'h0, 1, 0, rdv,   64'h0);
    for (int i = 12; i <= 16; i++)
      vecs[i] = mk(1, 0, 0, 18'h0,  32'h0,  0, 1, wa,      wd,           wjunk, 0, 1, wa,    wd,    1, 0, rdv,   64'h0);
    vecs[17] = mk(1, 0, 0, 18'h0,   32'h0,  0, 1, wa,      wd,           wjunk, 0, 1, wa,    wd,    1, 1, rdv,   64'h0);
    vecs[18] = mk(1, 0, 0, 18'h0,   32'h0,  0, 0, 18'h0,   32'h0,        wjunk, 0, 0, wa,    wd,    1, 1, rdv,   64'h0);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_mem_rd_en", i), mem_rd_en, vecs[i].e_rd);
      checkOutput($sformatf("v%0d_mem_wr_en", i), mem_wr_en, vecs[i].e_wr);
      checkOutput($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      checkOutput($sformatf("v%0d_mem_wdata", i), mem_write_data, vecs[i].e_wd);
      checkOutput($sformatf("v%0d_p0_ready", i), p0_ready, vecs[i].e_r0);
      checkOutput($sformatf("v%0d_p1_ready", i), p1_ready, vecs[i].e_r1);
      checkOutput($sformatf("v%0d_p0_rdata", i), p0_read_data, vecs[i].e_d0);
      checkOutput($sformatf("v%0d_p1_rdata", i), p1_read_data, vecs[i].e_d1);
    end

    // Simultaneous reads after reset: port 0 first, one idle cycle, then port 1.
    resetPulse();
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      p0_rd_en      = (k <= 6);
      p0_addr       = 18'h00010;
      p1_rd_en      = 1'b1;
      p1_addr       = 18'h00020;
      mem_read_data = (k <= 6) ? 64'h1111_1111_1111_1111 : 64'h2222_2222_2222_2222;
      #1;
      checkOutput($sformatf("sim%0d_mem_rd_en", k), mem_rd_en, (k != 0 && k != 7));
      checkOutput($sformatf("sim%0d_p0_ready", k), p0_ready, (k >= 6));
      checkOutput($sformatf("sim%0d_p1_ready", k), p1_ready, (k == 13));
      if (k >= 1 && k <= 6) checkOutput($sformatf("sim%0d_addr", k), mem_addr, 18'h00010);
      if (k >= 8)           checkOutput($sformatf("sim%0d_addr", k), mem_addr, 18'h00020);
      if (k == 6)  checkOutput("sim_p0_rdata", p0_read_data, 64'h1111_1111_1111_1111);
      if (k == 13) checkOutput("sim_p1_rdata", p1_read_data, 64'h2222_2222_2222_2222);
      if (k == 13) checkOutput("sim_p0_rdata_held", p0_read_data, 64'h1111_1111_1111_1111);
    end

    // Saturation: both ports request for six transactions; grants alternate with a 7-cycle period.
    for (int k = 0; k < 42; k++) begin
      int   t;
      int   ph;
      logic port;
      t  = k / 7;
      ph = k % 7;
      port = t[0];
      @(negedge clk);
      p0_rd_en      = 1'b1;
      p0_addr       = 18'h000A0;
      p1_rd_en      = 1'b1;
      p1_addr       = 18'h000B0;
      mem_read_data = 64'hC0DE_0000_0000_0000 | 64'(t);
      #1;
      if (ph == 0) begin
        checkOutput($sformatf("rr%0d_idle_rd_en", t), mem_rd_en, 1'b0);
        checkOutput($sformatf("rr%0d_idle_p0_ready", t), p0_ready, 1'b0);
        checkOutput($sformatf("rr%0d_idle_p1_ready", t), p1_ready, 1'b0);
      end else begin
        checkOutput($sformatf("rr%0d_%0d_rd_en", t, ph), mem_rd_en, 1'b1);
        checkOutput($sformatf("rr%0d_%0d_addr", t, ph), mem_addr, port ? 18'h000B0 : 18'h000A0);
        checkOutput($sformatf("rr%0d_%0d_p0_ready", t, ph), p0_ready, (ph == 6 && !port));
        checkOutput($sformatf("rr%0d_%0d_p1_ready", t, ph), p1_ready, (ph == 6 && port));
        if (ph == 6) begin
          if (port) checkOutput($sformatf("rr%0d_p1_rdata", t), p1_read_data, 64'hC0DE_0000_0000_0000 | 64'(t));
          else      checkOutput($sformatf("rr%0d_p0_rdata", t), p0_read_data, 64'hC0DE_0000_0000_0000 | 64'(t));
        end
      end
    end
    @(negedge clk);
    idleInputs();

    // Serve port 0 once so that only reset can make port 0 win the next tie.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      p0_rd_en = 1'b1;
      p0_addr  = 18'h000C0;
      #1;
      if (k == 6) checkOutput("pre_p0_ready", p0_ready, 1'b1);
    end
    @(negedge clk);
    idleInputs();

    // Port 1 write interrupted by reset in its third busy cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      p1_wr_en      = 1'b1;
      p1_addr       = 18'h3FFFF;
      p1_write_data = 32'hDEADBEEF;
      #1;
      if (k >= 1) checkOutput($sformatf("rmid%0d_wr_en", k), mem_wr_en, 1'b1);
    end
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rmid_async_wr_en", mem_wr_en, 1'b0);
    checkOutput("rmid_async_rd_en", mem_rd_en, 1'b0);
    checkOutput("rmid_p1_ready", p1_ready, 1'b1);
    @(negedge clk);
    rst      = 1'b1;
    p1_wr_en = 1'b0;
    p0_rd_en = 1'b1;
    p0_addr  = 18'h000C1;
    p1_rd_en = 1'b1;
    p1_addr  = 18'h000C2;
    #1;
    checkOutput("rpost_idle_rd_en", mem_rd_en, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("rpost_rd_en", mem_rd_en, 1'b1);
    checkOutput("rpost_first_addr", mem_addr, 18'h000C1);
    checkOutput("rpost_p1_ready", p1_ready, 1'b0);
    @(negedge clk);
    idleInputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
